// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Sequences an external shift register through load / N shifts /
//            capture, and presents the shifted value with a one-cycle done.
// Revision : 1.0  initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] operand,
    output logic             sh_load,
    output logic             sh_right,
    output logic             sh_left,
    output logic [WIDTH-1:0] sh_in_value,
    input  logic [WIDTH-1:0] sh_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Counts are held one bit wider than the input so count == WIDTH never wraps.
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(WIDTH);

    state_t           state;
    logic             dir_q;
    logic [CNT_W:0]   cnt_q;
    logic [CNT_W:0]   shift_cnt;
    logic [CNT_W:0]   count_clamped;

    // Requested shift distance, limited to the data width.
    always_comb begin
        count_clamped = {1'b0, count};
        if ({1'b0, count} > MAX_CNT) begin
            count_clamped = MAX_CNT;
        end
    end

    // Sequencer FSM; strobes are registered alongside the state so each one is
    // high for exactly the cycles its state is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            shift_cnt   <= '0;
            sh_load     <= 1'b0;
            sh_right    <= 1'b0;
            sh_left     <= 1'b0;
            sh_in_value <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // sh_in_value doubles as the latched operand.
                        sh_in_value <= operand;
                        dir_q       <= dir;
                        cnt_q       <= count_clamped;
                        sh_load     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    sh_load   <= 1'b0;
                    sh_right  <= ~dir_q;
                    sh_left   <= dir_q;
                    shift_cnt <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    // cnt_q+1 pulses: the extra one flushes the shifter's
                    // one-update output lag so sh_value shows the full shift.
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == cnt_q) begin
                        sh_right <= 1'b0;
                        sh_left  <= 1'b0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result <= sh_value;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    sh_load  <= 1'b0;
                    sh_right <= 1'b0;
                    sh_left  <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Directed bench for shift_sequencer with a behavioural lagging
//            shifter and a result/latency scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [WIDTH-1:0] operand = '0;
    logic             sh_load;
    logic             sh_right;
    logic             sh_left;
    logic [WIDTH-1:0] sh_in_value;
    logic [WIDTH-1:0] sh_value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Behavioural shifter: output shows the content before the latest update.
    logic [WIDTH-1:0] sh_reg = '0;
    logic [WIDTH-1:0] sh_prev = '0;
    assign sh_value = sh_prev;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
    } exp_t;
    exp_t sb[$];

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dir         (dir),
        .count       (count),
        .operand     (operand),
        .sh_load     (sh_load),
        .sh_right    (sh_right),
        .sh_left     (sh_left),
        .sh_in_value (sh_in_value),
        .sh_value    (sh_value),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Shifter register updated by the strobes, zero-filling vacated bits.
    always @(posedge clk) begin
        if (sh_load) begin
            sh_prev <= sh_reg;
            sh_reg  <= sh_in_value;
        end else if (sh_right) begin
            sh_prev <= sh_reg;
            sh_reg  <= sh_reg >> 1;
        end else if (sh_left) begin
            sh_prev <= sh_reg;
            sh_reg  <= sh_reg << 1;
        end
    end

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] op,
                                                   input logic d, input int n);
        logic [WIDTH-1:0] v;
        v = op;
        for (int i = 0; i < n; i++) begin
            v = d ? (v << 1) : (v >> 1);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"},
              {27'd0, sh_load, sh_right, sh_left, busy, done}, 32'd0);
        check({tag, "_sh_in_value"}, 32'(sh_in_value), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
    endtask

    // One job: start for one cycle, then observe up to cl+8 cycles.
    // restart_at > 0 re-asserts start in that cycle of the job.
    task automatic run_job(input logic [WIDTH-1:0] op, input logic d,
                           input int c, input int restart_at);
        int   cl;
        int   nload, nright, nleft, nexcl, ndone, nstrobe;
        exp_t e;
        exp_t got;
        cl = (c > WIDTH) ? WIDTH : c;
        nload = 0; nright = 0; nleft = 0; nexcl = 0; ndone = 0;
        @(negedge clk);
        operand = op;
        dir     = d;
        count   = CNT_W'(c);
        start   = 1'b1;
        e.res   = ref_shift(op, d, cl);
        e.lat   = cl + 4;
        sb.push_back(e);
        for (int cyc = 1; cyc <= cl + 8; cyc++) begin
            @(negedge clk);
            // Disturb the inputs mid-job; the job must not see it.
            start   = (cyc == restart_at);
            operand = ~op;
            dir     = ~d;
            count   = '0;
            nstrobe = 0;
            if (sh_load)  begin nload++;  nstrobe++; end
            if (sh_right) begin nright++; nstrobe++; end
            if (sh_left)  begin nleft++;  nstrobe++; end
            if (nstrobe > 1) nexcl++;
            if (done) begin
                ndone++;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("result", 32'(result), 32'(got.res));
                    check("latency", cyc, got.lat);
                end else begin
                    check("unexpected_done", sb.size(), 1);
                end
            end
        end
        start = 1'b0;
        check("load_pulses", nload, 1);
        check(d ? "left_pulses" : "right_pulses", d ? nleft : nright, cl + 1);
        check("wrong_dir_pulses", d ? nright : nleft, 0);
        check("exclusive", nexcl, 0);
        check("done_count", ndone, 1);
        check("busy_after", 32'(busy), 0);
        check("result_hold", 32'(result), 32'(e.res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(5'b10110, 1'b0, 2, 0);   // -> 00101, done in cycle 6
        run_job(5'b10110, 1'b1, 1, 0);   // -> 01100, done in cycle 5
        run_job(5'b11011, 1'b0, 0, 0);   // -> 11011, done in cycle 4
        run_job(5'b11111, 1'b0, 7, 0);   // clamped to 5 -> 00000
        run_job(5'b10101, 1'b1, 4, 0);   // -> 10000
        run_job(5'b01101, 1'b1, 5, 0);   // -> 00000
        run_job(5'b10110, 1'b0, 2, 3);   // start again in cycle 3: ignored

        // Mid-job reset during SHIFT.
        @(negedge clk);
        operand = 5'b10110;
        dir     = 1'b0;
        count   = 3'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("shift_before_reset", 32'(sh_right), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold_outs",
                  {27'd0, sh_load, sh_right, sh_left, busy, done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_idle", {30'd0, busy, done}, 32'd0);
        end
        run_job(5'b00011, 1'b1, 1, 0);   // fresh job -> 00110

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
